// File: rtl/doppler_spi_regfile_if.sv
// SPI link between the SAMD51 host (master) and the ice40 register controller (slave).
interface doppler_spi_regfile_if;
  logic spi_cs;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs, output spi_sck, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs, input spi_sck, input spi_mosi, output spi_miso);
endinterface

// File: rtl/doppler_spi_regfile.sv
// SPI-slave register controller: decodes 24-bit command frames from the host,
// owns the LED / pin-output / output-enable registers and returns the addressed
// register on MISO within the same frame.
// Optional feature macro: DOPPLER_EDGE_CAPTURE_EN (sticky rising-edge capture
// register at address 0x4; when undefined, 0x4 reads 16'h0000).
// SYNC_STAGES must be at least 2.
module doppler_spi_regfile #(
  parameter logic [15:0] ID_VALUE    = 16'hD001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  doppler_spi_regfile_if.slave    spi,
  input  logic [15:0]             pin_in,
  output logic [15:0]             led_bits,
  output logic [15:0]             pin_out,
  output logic [15:0]             pin_oe,
  output logic                    wr_strobe,
  output logic [3:0]              wr_addr,
  output logic                    frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_OVER} state_t;

  state_t                        r_state, w_state_nxt;
  logic [4:0]                    r_cnt, w_cnt_nxt;
  // One extra stage on cs/sck holds the previous synced value for edge detection.
  logic [SYNC_STAGES:0]          r_cs_sync, r_sck_sync;
  logic [SYNC_STAGES-1:0]        r_mosi_sync;
  logic [SYNC_STAGES-1:0][15:0]  r_pin_sync;
  logic [23:0]                   r_shift_in;
  logic [15:0]                   r_miso_sr;
  logic [15:0]                   r_led, r_pin_out, r_pin_oe;
  logic                          r_wr_strobe, r_frame_err;
  logic [3:0]                    r_wr_addr;

  logic        w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall, w_mosi;
  logic [15:0] w_pin_sync, w_edge_val, w_rd_data;
  logic        w_frame_err, w_commit, w_load, w_shift_miso, w_shift_in;
  logic        w_load_bad, w_load_read;

  assign w_cs_rise  =  r_cs_sync[SYNC_STAGES-1]  & ~r_cs_sync[SYNC_STAGES];
  assign w_cs_fall  = ~r_cs_sync[SYNC_STAGES-1]  &  r_cs_sync[SYNC_STAGES];
  assign w_sck_rise =  r_sck_sync[SYNC_STAGES-1] & ~r_sck_sync[SYNC_STAGES];
  assign w_sck_fall = ~r_sck_sync[SYNC_STAGES-1] &  r_sck_sync[SYNC_STAGES];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_pin_sync = r_pin_sync[SYNC_STAGES-1];

  // Command byte sits in the low byte of the input shifter at MISO load time.
  assign w_load_bad  = (r_shift_in[6:4] != 3'b000);
  assign w_load_read = ~r_shift_in[7] & ~w_load_bad;

  // Synchronize the asynchronous SPI pins and pin bank. The cs chain resets to 0
  // so a frame already running when reset releases never produces a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cs_sync   <= '0;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_pin_sync  <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-1:0], spi.spi_cs};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-1:0], spi.spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      r_pin_sync  <= {r_pin_sync[SYNC_STAGES-2:0], pin_in};
    end
  end

`ifdef DOPPLER_EDGE_CAPTURE_EN
  logic [15:0] r_pin_prev, r_edge;
  logic        w_edge_clr;
  assign w_edge_clr = w_load & w_load_read & (r_shift_in[3:0] == 4'h4);
  assign w_edge_val = r_edge;

  // Sticky rising-edge capture; a new edge in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pin_prev <= '0;
      r_edge     <= '0;
    end else begin
      r_pin_prev <= w_pin_sync;
      r_edge     <= (w_edge_clr ? 16'h0000 : r_edge) | (w_pin_sync & ~r_pin_prev);
    end
  end
`else
  assign w_edge_val = 16'h0000;
`endif

  // Read mux for the register returned on MISO; malformed commands read zero.
  always_comb begin
    w_rd_data = 16'h0000;
    if (!w_load_bad) begin
      case (r_shift_in[3:0])
        4'h0:    w_rd_data = r_led;
        4'h1:    w_rd_data = r_pin_out;
        4'h2:    w_rd_data = r_pin_oe;
        4'h3:    w_rd_data = w_pin_sync;
        4'h4:    w_rd_data = w_edge_val;
        4'h5:    w_rd_data = ID_VALUE;
        default: w_rd_data = 16'h0000;
      endcase
    end
  end

  // Frame FSM state and saturating bit counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state decode plus the per-cycle shift/load/commit/error controls.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_frame_err  = 1'b0;
    w_commit     = 1'b0;
    w_load       = 1'b0;
    w_shift_miso = 1'b0;
    w_shift_in   = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
      if (r_state == ST_CMD || r_state == ST_DATA) w_frame_err = 1'b1;
      if (r_state == ST_OVER && r_cnt == 5'd24 && r_shift_in[23] &&
          r_shift_in[22:20] == 3'b000 && r_shift_in[19:16] <= 4'h2)
        w_commit = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            w_state_nxt = ST_CMD;
            w_cnt_nxt   = 5'd0;
          end
        end
        ST_CMD: begin
          if (w_sck_rise) begin
            w_shift_in = 1'b1;
            w_cnt_nxt  = r_cnt + 5'd1;
            if (r_cnt == 5'd7) w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_sck_rise) begin
            w_shift_in = 1'b1;
            w_cnt_nxt  = r_cnt + 5'd1;
            if (r_cnt == 5'd23) w_state_nxt = ST_OVER;
          end
          if (w_sck_fall) begin
            if (r_cnt == 5'd8) begin
              w_load      = 1'b1;
              w_frame_err = w_load_bad;
            end else begin
              w_shift_miso = 1'b1;
            end
          end
        end
        ST_OVER: begin
          // 25th bit flags a long frame; the counter then sticks at 25.
          if (w_sck_rise && r_cnt == 5'd24) begin
            w_cnt_nxt   = 5'd25;
            w_frame_err = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shifters, register file updates and single-cycle status pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift_in  <= '0;
      r_miso_sr   <= '1;
      r_led       <= '0;
      r_pin_out   <= '0;
      r_pin_oe    <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= w_commit;
      r_frame_err <= w_frame_err;
      if (w_shift_in) r_shift_in <= {r_shift_in[22:0], w_mosi};
      if (w_load)            r_miso_sr <= w_rd_data;
      else if (w_shift_miso) r_miso_sr <= {r_miso_sr[14:0], 1'b1};
      if (w_commit) begin
        r_wr_addr <= r_shift_in[19:16];
        case (r_shift_in[19:16])
          4'h0:    r_led     <= r_shift_in[15:0];
          4'h1:    r_pin_out <= r_shift_in[15:0];
          default: r_pin_oe  <= r_shift_in[15:0];
        endcase
      end
    end
  end

  assign spi.spi_miso = (r_state == ST_DATA) ? r_miso_sr[15] : 1'b1;
  assign led_bits     = r_led;
  assign pin_out      = r_pin_out;
  assign pin_oe       = r_pin_oe;
  assign wr_strobe    = r_wr_strobe;
  assign wr_addr      = r_wr_addr;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_doppler_spi_regfile.sv
// Bench for doppler_spi_regfile: directed frames from the bring-up list followed
// by randomized frames, all checked against a behavioural register-map model.
// Honours DOPPLER_EDGE_CAPTURE_EN in the same way as the design.
module tb_doppler_spi_regfile;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] pin_in = 16'h0000;
  logic [15:0] led_bits, pin_out, pin_oe;
  logic        wr_strobe, frame_err;
  logic [3:0]  wr_addr;

  doppler_spi_regfile_if spi_if ();

  doppler_spi_regfile #(.ID_VALUE(16'hD001), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .spi       (spi_if.slave),
    .pin_in    (pin_in),
    .led_bits  (led_bits),
    .pin_out   (pin_out),
    .pin_oe    (pin_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_strobe = 0;
  int n_err = 0;

  // Reference register map.
  logic [15:0] m_led = 16'h0, m_out = 16'h0, m_oe = 16'h0, m_edge = 16'h0;
  logic [3:0]  m_waddr = 4'h0;

  // Count pulse cycles; a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (wr_strobe) n_strobe++;
    if (frame_err) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [7:0] cmd);
    if (cmd[6:4] != 3'b000) return 16'h0000;
    case (cmd[3:0])
      4'h0: return m_led;
      4'h1: return m_out;
      4'h2: return m_oe;
      4'h3: return pin_in;
`ifdef DOPPLER_EDGE_CAPTURE_EN
      4'h4: return m_edge;
`endif
      4'h5: return 16'hD001;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic void m_reset();
    m_led = 16'h0; m_out = 16'h0; m_oe = 16'h0; m_edge = 16'h0; m_waddr = 4'h0;
  endfunction

  task automatic set_pins(input logic [15:0] v);
`ifdef DOPPLER_EDGE_CAPTURE_EN
    m_edge = m_edge | (v & ~pin_in);
`endif
    pin_in = v;
    repeat (8) @(negedge clk);
  endtask

  // Host side of one frame: nbits bits MSB first, sck half period 6 clk.
  // If rst_at matches a bit index, resetn pulses low while that bit is set up.
  task automatic spi_xfer(input int nbits, input logic [31:0] word, input int rst_at,
                          output logic [15:0] rx);
    rx = 16'h0000;
    @(negedge clk);
    spi_if.spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_if.spi_mosi = word[nbits-1-i];
      if (i == rst_at) begin
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
      end
      repeat (6) @(negedge clk);
      if (i >= 8 && i < 24) rx = {rx[14:0], spi_if.spi_miso};
      spi_if.spi_sck = 1'b1;
      repeat (6) @(negedge clk);
      spi_if.spi_sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    spi_if.spi_cs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Run one frame and check everything the model predicts for it.
  task automatic frame(input int nbits, input logic [7:0] cmd, input logic [15:0] data,
                       input string tag);
    logic [15:0] exp_rx, rx;
    logic [31:0] full, word;
    int exp_err, exp_str, s0, e0;
    s0 = n_strobe;
    e0 = n_err;
    exp_rx = m_read(cmd);
    exp_err = 0;
    exp_str = 0;
    if (nbits >= 8 && !cmd[7] && cmd[6:4] == 3'b000 && cmd[3:0] == 4'h4) m_edge = 16'h0;
    if (nbits < 24) exp_err++;
    if (nbits > 24) exp_err++;
    if (nbits >= 8 && cmd[6:4] != 3'b000) exp_err++;
    if (nbits == 24 && cmd[7] && cmd[6:4] == 3'b000 && cmd[3:0] < 4'h3) begin
      exp_str = 1;
      m_waddr = cmd[3:0];
      if (cmd[3:0] == 4'h0) m_led = data;
      else if (cmd[3:0] == 4'h1) m_out = data;
      else m_oe = data;
    end
    full = {8'h00, cmd, data};
    word = (nbits >= 24) ? (full << (nbits - 24)) : (full >> (24 - nbits));
    spi_xfer(nbits, word, -1, rx);
    if (nbits >= 24) check({tag, ".miso_data"}, {16'h0, rx}, {16'h0, exp_rx});
    check({tag, ".wr_strobe_cnt"}, n_strobe - s0, exp_str);
    check({tag, ".frame_err_cnt"}, n_err - e0, exp_err);
    check({tag, ".led_bits"}, {16'h0, led_bits}, {16'h0, m_led});
    check({tag, ".pin_out"}, {16'h0, pin_out}, {16'h0, m_out});
    check({tag, ".pin_oe"}, {16'h0, pin_oe}, {16'h0, m_oe});
    check({tag, ".wr_addr"}, {28'h0, wr_addr}, {28'h0, m_waddr});
    check({tag, ".miso_idle"}, {31'h0, spi_if.spi_miso}, 32'h1);
  endtask

  initial begin
    logic [15:0] rx;
    int s0, e0, nb;
    logic [7:0] cmd;
    spi_if.spi_cs = 1'b1;
    spi_if.spi_sck = 1'b0;
    spi_if.spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    // Reset state, no SPI activity.
    check("rst.led_bits", {16'h0, led_bits}, 32'h0);
    check("rst.pin_out", {16'h0, pin_out}, 32'h0);
    check("rst.pin_oe", {16'h0, pin_oe}, 32'h0);
    check("rst.miso", {31'h0, spi_if.spi_miso}, 32'h1);
    check("rst.wr_addr", {28'h0, wr_addr}, 32'h0);
    check("rst.pulses", n_strobe + n_err, 32'h0);

    // Write LED then read it back.
    frame(24, 8'h80, 16'hA55A, "wr_led");
    check("wr_led.value", {16'h0, led_bits}, 32'h0000A55A);
    frame(24, 8'h00, 16'h0000, "rd_led");

    // Direction, output, input and ID registers.
    frame(24, 8'h82, 16'h00FF, "wr_oe");
    frame(24, 8'h81, 16'h0F0F, "wr_out");
    set_pins(16'h1234);
    frame(24, 8'h03, 16'h0000, "rd_pin_in");
    frame(24, 8'h05, 16'h0000, "rd_id");
    check("oe.value", {16'h0, pin_oe}, 32'h000000FF);
    check("out.value", {16'h0, pin_out}, 32'h00000F0F);

    // Short and long frames, write to RO address, reserved command bits.
    frame(16, 8'h80, 16'h1111, "short");
    frame(25, 8'h80, 16'h2222, "long");
    check("short_long.led", {16'h0, led_bits}, 32'h0000A55A);
    frame(24, 8'h85, 16'h3333, "wr_ro");
    frame(24, 8'h90, 16'h4444, "bad_cmd");

    // Reset in the middle of a write, then a clean frame.
    set_pins(16'h0000);
    s0 = n_strobe;
    e0 = n_err;
    spi_xfer(24, {8'h00, 8'h81, 16'hFFFF}, 11, rx);
    m_reset();
    check("midrst.pin_out", {16'h0, pin_out}, 32'h0);
    check("midrst.led", {16'h0, led_bits}, 32'h0);
    check("midrst.pulses", (n_strobe - s0) + (n_err - e0), 32'h0);
    frame(24, 8'h81, 16'hC3C3, "after_rst");

    // Edge capture: rising pin_in[3] then two reads of 0x4.
    set_pins(16'h0008);
    frame(24, 8'h04, 16'h0000, "edge_rd1");
    frame(24, 8'h04, 16'h0000, "edge_rd2");

    // Randomized frames.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) set_pins(16'($urandom));
      cmd = {1'($urandom), 3'b000, 4'($urandom_range(0, 7))};
      if ($urandom_range(0, 7) == 0) cmd[6:4] = 3'($urandom_range(1, 7));
      case ($urandom_range(0, 7))
        0: nb = 16;
        1: nb = 25;
        2: nb = 5;
        3: nb = 26;
        default: nb = 24;
      endcase
      frame(nb, cmd, 16'($urandom), $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
